trace_capture_unit: RTL and testbench
=====================================

// Module: trace_capture_unit
// PURPOSE
//  Parametrised, synthesizable successor to the per-cycle $strobe debug monitor.
//  Snoops the CPU PC, the ROB commit mask and NCH writeback channels every cycle.
//  Records them into a circular on-chip trace buffer, with PC-match trigger and post-trigger window.
//  After capture stops, trace is drained oldest-first over a valid/ready port to the debug host.
// PARAMETERS
//  NCH       3   writeback channels snooped (writebus width)
//  IQ_DEPTH  8   issue-queue/ROB slots; width of commit_mask
//  IQPOS_W   3   iq_pos field width per channel
//  ADDR_W    5   register address width per channel
//  DATA_W    32  data width per channel
//  DEPTH     64  trace entries; power of two
//  CYC_W     16  cycle-stamp width
//  ENT_W = 1+CYC_W+32+IQ_DEPTH+NCH*(1+IQPOS_W+ADDR_W+DATA_W)  (derived localparam)
// PORTS
//  clk         in   1                  clock; all logic on posedge
//  rst         in   1                  synchronous active-high reset
//  arm         in   1                  pulse: clear buffer, start capture (ARMED)
//  stop        in   1                  pulse: force end of capture (-> DONE)
//  mode        in   1                  0 = record every cycle, 1 = record only event cycles
//  trig_en     in   1                  enable PC-match trigger
//  trig_pc     in   32                 trigger PC
//  post_cnt    in   $clog2(DEPTH)      entries recorded after trigger entry; sampled at trigger
//  pc          in   32                 current fetch PC
//  commit_mask in   IQ_DEPTH           ROB slots committing this cycle
//  wb_we       in   NCH                per-channel writeback valid
//  wb_iqpos    in   NCH*IQPOS_W        packed, channel 0 in LSBs
//  wb_addr     in   NCH*ADDR_W         packed
//  wb_data     in   NCH*DATA_W         packed
//  rd_ready    in   1                  host accepts rd_data
//  rd_valid    out  1                  rd_data holds a trace entry
//  rd_data     out  ENT_W              {trig_flag, cycle, pc, commit_mask, channel fields}
//  rd_last     out  1                  rd_data is the final entry
//  state       out  2                  0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  count       out  $clog2(DEPTH)+1    valid entries held; saturates at DEPTH
//  wrapped     out  1                  at least one entry was overwritten since arm
// BEHAVIOUR
//  Reset: state IDLE; rd_valid, rd_last, rd_data, count, wrapped = 0.
//  Reset also clears the cycle stamp and wr_ptr; buffer contents are don't-care.
//  Reset mid-capture or mid-drain drops everything.
//  Cycle stamp: free-running from reset, +1 per clk, wraps modulo 2^CYC_W.
//  Event cycle: |wb_we or |commit_mask or trigger hit.
//  Record cycle in ARMED/POST: mode==0, or an event cycle.
//  Record: write entry at wr_ptr, wr_ptr+1 mod DEPTH.
//  If count==DEPTH the oldest entry is overwritten and wrapped<=1; otherwise count+1.
//  Trigger hit: state ARMED and trig_en and pc==trig_pc.
//  On a hit the entry is recorded regardless of mode, with trig_flag=1.
//  Next state is POST with remain=min(post_cnt,DEPTH-1), or DONE if that value is 0.
//  POST: each record decrements remain; the record that brings it to 0 moves to DONE.
//  Trigger matches are ignored in POST.
//  stop in ARMED/POST: that cycle's record still happens; next state DONE.
//  stop in IDLE/DONE: ignored.
//  arm in IDLE/ARMED/POST/DONE: count=0, wrapped=0, wr_ptr=0, next state ARMED.
//  Nothing is recorded on the arm cycle. arm and stop together: arm wins.
//  arm while DONE with rd_valid=1 aborts the drain; rd_valid drops next cycle.
//  DONE drain: rd_ptr=(wr_ptr-count) mod DEPTH, i.e. oldest first.
//  rd_valid rises exactly 1 cycle after entering DONE when count>0.
//  If count==0, DONE moves to IDLE next cycle and rd_valid stays 0.
//  Handshake: rd_data/rd_last hold stable while rd_valid && !rd_ready.
//  On rd_valid && rd_ready: pop, count-1, and the next entry is presented the following cycle.
//  Back-to-back pops sustain one entry per cycle.
//  rd_last=1 iff count==1. Popping the last entry clears rd_valid and moves to IDLE.
//  Inputs are captured in the cycle they are presented; no combinational path from inputs to outputs.
// TESTING
//  mode0, arm, 10 cycles, stop -> count=10, 10 entries drained with consecutive cycle stamps, rd_last on 10th.
//  mode1, events only on cycles 3 and 7 after arm -> count=2, stamps differ by 4, wrapped=0.
//  mode0, DEPTH=64, 100 cycles then stop -> count=64, wrapped=1, first drained entry is the 37th recorded.
//  trig_pc=0x40, post_cnt=5, hit -> 6 entries after trigger (trig_flag only on first), state DONE, later 0x40 ignored.
//  drain with rd_ready toggling 1/0 -> rd_data stable while stalled, no entry lost or duplicated.
//  rst asserted mid-POST and mid-drain -> state IDLE, rd_valid=0, count=0 on next cycle.

Source files
------------

// File: rtl/trace_capture_unit.sv
// trace_capture_unit: circular trace buffer snooping PC, commits and writeback.
// Captures until the post-trigger window closes or stop, then drains oldest-first.
module trace_capture_unit #(
  parameter int NCH      = 3,
  parameter int IQ_DEPTH = 8,
  parameter int IQPOS_W  = 3,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int CYC_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          mode,
  input  logic                          trig_en,
  input  logic [31:0]                   trig_pc,
  input  logic [$clog2(DEPTH)-1:0]      post_cnt,
  input  logic [31:0]                   pc,
  input  logic [IQ_DEPTH-1:0]           commit_mask,
  input  logic [NCH-1:0]                wb_we,
  input  logic [NCH*IQPOS_W-1:0]        wb_iqpos,
  input  logic [NCH*ADDR_W-1:0]         wb_addr,
  input  logic [NCH*DATA_W-1:0]         wb_data,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [1+CYC_W+32+IQ_DEPTH+NCH*(1+IQPOS_W+ADDR_W+DATA_W)-1:0] rd_data,
  output logic                          rd_last,
  output logic [1:0]                    state,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          wrapped
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CH_W  = 1 + IQPOS_W + ADDR_W + DATA_W;
  localparam int ENT_W = 1 + CYC_W + 32 + IQ_DEPTH + NCH * CH_W;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              st;
  logic [CYC_W-1:0]    cyc;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       remain;
  logic [PW-1:0]       head;
  logic [NCH*CH_W-1:0] chans;
  logic [ENT_W-1:0]    entry;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic                capturing;
  logic                hit;
  logic                evt;
  logic                rec;
  logic                wr_en;

  assign state     = st;
  assign capturing = (st == S_ARMED) || (st == S_POST);
  assign hit       = (st == S_ARMED) && trig_en && (pc == trig_pc);
  assign evt       = (|wb_we) || (|commit_mask) || hit;
  assign rec       = capturing && (!mode || evt);
  assign wr_en     = rec && !arm && !rst;
  assign head      = wr_ptr - count[PW-1:0];

  // each channel packs as {we, iq_pos, addr, data}, channel 0 in the LSBs
  always_comb begin
    chans = '0;
    for (int i = 0; i < NCH; i++) begin
      chans[i*CH_W +: CH_W] = {wb_we[i],
                               wb_iqpos[i*IQPOS_W +: IQPOS_W],
                               wb_addr[i*ADDR_W +: ADDR_W],
                               wb_data[i*DATA_W +: DATA_W]};
    end
  end

  assign entry = {hit, cyc, pc, commit_mask, chans};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      cyc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      remain   <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (arm) begin
        st       <= S_ARMED;
        count    <= '0;
        wrapped  <= 1'b0;
        wr_ptr   <= '0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else begin
        unique case (st)
          S_ARMED, S_POST: begin
            if (rec) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (count == FULL) wrapped <= 1'b1;
              else count <= count + 1'b1;
            end
            if (stop) begin
              st <= S_DONE;
            end else if (hit) begin
              remain <= post_cnt;
              st     <= (post_cnt == '0) ? S_DONE : S_POST;
            end else if (st == S_POST && rec) begin
              remain <= remain - 1'b1;
              if (remain == PW'(1)) st <= S_DONE;
            end
          end
          S_DONE: begin
            if (!rd_valid) begin
              if (count == '0) begin
                st <= S_IDLE;
              end else begin
                rd_data  <= mem[head];
                rd_ptr   <= head;
                rd_valid <= 1'b1;
                rd_last  <= (count == (PW + 1)'(1));
              end
            end else if (rd_ready) begin
              count <= count - 1'b1;
              if (count == (PW + 1)'(1)) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                st       <= S_IDLE;
              end else begin
                rd_data <= mem[rd_ptr + 1'b1];
                rd_ptr  <= rd_ptr + 1'b1;
                rd_last <= (count == (PW + 1)'(2));
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_unit.sv
// tb_trace_capture_unit: random-stimulus bench for the trace capture unit.
// A queue-based model predicts buffer contents, state and drain order.
module tb_trace_capture_unit;

  localparam int NCH      = 3;
  localparam int IQ_DEPTH = 8;
  localparam int IQPOS_W  = 3;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 64;
  localparam int CYC_W    = 16;
  localparam int PW       = $clog2(DEPTH);
  localparam int CH_W     = 1 + IQPOS_W + ADDR_W + DATA_W;
  localparam int ENT_W    = 1 + CYC_W + 32 + IQ_DEPTH + NCH * CH_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   arm = 1'b0;
  logic                   stop = 1'b0;
  logic                   mode = 1'b0;
  logic                   trig_en = 1'b0;
  logic [31:0]            trig_pc = '0;
  logic [PW-1:0]          post_cnt = '0;
  logic [31:0]            pc = '0;
  logic [IQ_DEPTH-1:0]    commit_mask = '0;
  logic [NCH-1:0]         wb_we = '0;
  logic [NCH*IQPOS_W-1:0] wb_iqpos = '0;
  logic [NCH*ADDR_W-1:0]  wb_addr = '0;
  logic [NCH*DATA_W-1:0]  wb_data = '0;
  logic                   rd_ready = 1'b0;
  logic                   rd_valid;
  logic [ENT_W-1:0]       rd_data;
  logic                   rd_last;
  logic [1:0]             state;
  logic [PW:0]            count;
  logic                   wrapped;

  int vecs = 0;
  int errs = 0;

  int               m_state = 0;
  int               m_remain = 0;
  int               m_cyc = 0;
  bit               m_wrapped = 0;
  bit               m_valid = 0;
  logic [ENT_W-1:0] m_q[$];
  logic [ENT_W-1:0] drained[$];
  int               arm_stamp;

  always #5 clk = ~clk;

  trace_capture_unit dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .pc(pc), .commit_mask(commit_mask), .wb_we(wb_we),
    .wb_iqpos(wb_iqpos), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .state(state), .count(count), .wrapped(wrapped)
  );

  function automatic logic [ENT_W-1:0] mk_entry(input logic flag, input int stamp);
    logic [NCH*CH_W-1:0] ch;
    for (int i = 0; i < NCH; i++)
      ch[i*CH_W +: CH_W] = {wb_we[i], wb_iqpos[i*IQPOS_W +: IQPOS_W],
                            wb_addr[i*ADDR_W +: ADDR_W], wb_data[i*DATA_W +: DATA_W]};
    return {flag, CYC_W'(stamp), pc, commit_mask, ch};
  endfunction

  // trace buffer = the last DEPTH recorded cycles; states 0..3 as on the port
  task automatic model_step();
    bit hit;
    bit rec;
    int stamp;
    if (rst) begin
      m_state = 0; m_q.delete(); m_wrapped = 0; m_valid = 0; m_cyc = 0;
      return;
    end
    stamp = m_cyc;
    m_cyc = (m_cyc + 1) % (1 << CYC_W);
    if (arm) begin
      m_q.delete(); m_wrapped = 0; m_valid = 0; m_state = 1;
      return;
    end
    if (m_state == 1 || m_state == 2) begin
      hit = (m_state == 1) && trig_en && (pc == trig_pc);
      rec = !mode || hit || (wb_we != 0) || (commit_mask != 0);
      if (rec) begin
        m_q.push_back(mk_entry(hit, stamp));
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_wrapped = 1;
        end
      end
      if (stop) m_state = 3;
      else if (hit) begin
        m_remain = int'(post_cnt);
        m_state = (m_remain == 0) ? 3 : 2;
      end else if (m_state == 2 && rec) begin
        m_remain--;
        if (m_remain == 0) m_state = 3;
      end
    end else if (m_state == 3) begin
      if (!m_valid) begin
        if (m_q.size() == 0) m_state = 0;
        else m_valid = 1;
      end else if (rd_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_valid = 0;
          m_state = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    pc = $urandom | 32'h100;
    commit_mask = '0;
    wb_we = '0;
    wb_iqpos = (NCH*IQPOS_W)'($urandom);
    wb_addr = (NCH*ADDR_W)'($urandom);
    wb_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic set_busy();
    set_quiet();
    commit_mask = IQ_DEPTH'($urandom);
    wb_we = NCH'($urandom);
    if (commit_mask == 0 && wb_we == 0) wb_we = 3'b001;
  endtask

  task automatic set_mix();
    if ($urandom_range(1, 0) == 1) set_busy();
    else set_quiet();
  endtask

  task automatic pulse_arm();
    arm_stamp = m_cyc;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 1; i <= n; i++) begin
      set_mix();
      stop = (i == n);
      tick();
    end
    stop = 1'b0;
    set_quiet();
  endtask

  task automatic do_drain(input string tag, input bit toggle);
    int n = 0;
    drained.delete();
    rd_ready = 1'b1;
    while (m_state == 3 && n < 300) begin
      if (toggle) rd_ready = (n % 2 == 0);
      vecs++;
      if (rd_valid !== m_valid) begin
        errs++;
        $display("FAIL %s rd_valid: got %b want %b", tag, rd_valid, m_valid);
      end
      if (m_valid) begin
        vecs++;
        if (rd_data !== m_q[0]) begin
          errs++;
          $display("FAIL %s rd_data: got %h want %h", tag, rd_data, m_q[0]);
        end
        vecs++;
        if (rd_last !== (m_q.size() == 1)) begin
          errs++;
          $display("FAIL %s rd_last: got %b want %b", tag, rd_last, m_q.size() == 1);
        end
      end
      vecs++;
      if (count !== (PW+1)'(m_q.size())) begin
        errs++;
        $display("FAIL %s count: got %0d want %0d", tag, count, m_q.size());
      end
      if (rd_valid && rd_ready) drained.push_back(rd_data);
      tick();
      n++;
    end
    rd_ready = 1'b0;
    vecs++;
    if (n >= 300) begin
      errs++;
      $display("FAIL %s timeout: drain did not finish in 300 cycles", tag);
    end
    vecs++;
    if (state !== 2'd0 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s end: got state %0d valid %b want 0 0", tag, state, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++;
    if (state !== 2'd0) begin errs++; $display("FAIL reset state: got %0d want 0", state); end
    vecs++;
    if (rd_valid !== 1'b0) begin errs++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
    vecs++;
    if (rd_last !== 1'b0) begin errs++; $display("FAIL reset rd_last: got %b want 0", rd_last); end
    vecs++;
    if (rd_data !== '0) begin errs++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
    vecs++;
    if (count !== '0) begin errs++; $display("FAIL reset count: got %0d want 0", count); end
    vecs++;
    if (wrapped !== 1'b0) begin errs++; $display("FAIL reset wrapped: got %b want 0", wrapped); end
  endtask

  task automatic test_mode0_basic();
    mode = 1'b0;
    pulse_arm();
    vecs++;
    if (state !== 2'd1 || count !== '0) begin
      errs++;
      $display("FAIL basic armed: got state %0d count %0d want 1 0", state, count);
    end
    capture(10);
    vecs++;
    if (state !== 2'd3 || count !== 7'd10 || wrapped !== 1'b0) begin
      errs++;
      $display("FAIL basic done: got st %0d cnt %0d wr %b want 3 10 0", state, count, wrapped);
    end
    do_drain("basic", 1'b0);
    vecs++;
    if (drained.size() != 10) begin
      errs++;
      $display("FAIL basic drained: got %0d want 10", drained.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vecs++;
        if (drained[i][ENT_W-2 -: CYC_W] !== CYC_W'(arm_stamp + 1 + i)) begin
          errs++;
          $display("FAIL basic stamp%0d: got %0d want %0d", i,
                   drained[i][ENT_W-2 -: CYC_W], CYC_W'(arm_stamp + 1 + i));
        end
      end
    end
  endtask

  task automatic test_mode1_events();
    mode = 1'b1;
    pulse_arm();
    for (int i = 1; i <= 10; i++) begin
      if (i == 3 || i == 7) set_busy();
      else set_quiet();
      stop = (i == 10);
      tick();
    end
    stop = 1'b0;
    vecs++;
    if (state !== 2'd3 || count !== 7'd2 || wrapped !== 1'b0) begin
      errs++;
      $display("FAIL events done: got st %0d cnt %0d wr %b want 3 2 0", state, count, wrapped);
    end
    do_drain("events", 1'b0);
    vecs++;
    if (drained.size() != 2) begin
      errs++;
      $display("FAIL events drained: got %0d want 2", drained.size());
    end else begin
      vecs++;
      if (drained[1][ENT_W-2 -: CYC_W] - drained[0][ENT_W-2 -: CYC_W] !== CYC_W'(4)) begin
        errs++;
        $display("FAIL events gap: got %0d want 4",
                 drained[1][ENT_W-2 -: CYC_W] - drained[0][ENT_W-2 -: CYC_W]);
      end
    end
  endtask

  task automatic test_wrap();
    mode = 1'b0;
    pulse_arm();
    capture(100);
    vecs++;
    if (state !== 2'd3 || count !== 7'd64 || wrapped !== 1'b1) begin
      errs++;
      $display("FAIL wrap done: got st %0d cnt %0d wr %b want 3 64 1", state, count, wrapped);
    end
    do_drain("wrap", 1'b0);
    vecs++;
    if (drained.size() != 64) begin
      errs++;
      $display("FAIL wrap drained: got %0d want 64", drained.size());
    end else begin
      vecs++;
      if (drained[0][ENT_W-2 -: CYC_W] !== CYC_W'(arm_stamp + 37)) begin
        errs++;
        $display("FAIL wrap first: got %0d want %0d",
                 drained[0][ENT_W-2 -: CYC_W], CYC_W'(arm_stamp + 37));
      end
    end
  endtask

  task automatic test_trigger();
    mode = 1'b1;
    trig_en = 1'b1;
    trig_pc = 32'h40;
    post_cnt = PW'(5);
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      set_quiet();
      tick();
    end
    set_quiet();
    pc = 32'h40;
    tick();
    vecs++;
    if (state !== 2'd2) begin errs++; $display("FAIL trig hit: got state %0d want 2", state); end
    for (int j = 1; j <= 6; j++) begin
      if (j == 3) set_quiet();
      else set_busy();
      if (j == 2) pc = 32'h40;
      tick();
      vecs++;
      if (state !== ((j < 6) ? 2'd2 : 2'd3)) begin
        errs++;
        $display("FAIL trig post%0d: got state %0d want %0d", j, state, (j < 6) ? 2 : 3);
      end
    end
    vecs++;
    if (count !== 7'd6) begin errs++; $display("FAIL trig count: got %0d want 6", count); end
    set_quiet();
    do_drain("trig", 1'b0);
    trig_en = 1'b0;
    vecs++;
    if (drained.size() != 6) begin
      errs++;
      $display("FAIL trig drained: got %0d want 6", drained.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vecs++;
        if (drained[i][ENT_W-1] !== (i == 0)) begin
          errs++;
          $display("FAIL trig flag%0d: got %b want %b", i, drained[i][ENT_W-1], i == 0);
        end
      end
    end
  endtask

  task automatic test_toggle_drain();
    mode = 1'b0;
    pulse_arm();
    capture(20);
    do_drain("toggle", 1'b1);
    vecs++;
    if (drained.size() != 20) begin
      errs++;
      $display("FAIL toggle drained: got %0d want 20", drained.size());
    end
  endtask

  task automatic test_empty_abort();
    mode = 1'b1;
    pulse_arm();
    for (int i = 1; i <= 3; i++) begin
      set_quiet();
      stop = (i == 3);
      tick();
    end
    stop = 1'b0;
    vecs++;
    if (state !== 2'd3 || count !== '0) begin
      errs++;
      $display("FAIL empty done: got st %0d cnt %0d want 3 0", state, count);
    end
    tick();
    vecs++;
    if (state !== 2'd0 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL empty idle: got st %0d valid %b want 0 0", state, rd_valid);
    end
    mode = 1'b0;
    pulse_arm();
    capture(5);
    rd_ready = 1'b0;
    tick();
    vecs++;
    if (rd_valid !== 1'b1) begin errs++; $display("FAIL abort valid: got %b want 1", rd_valid); end
    arm_stamp = m_cyc;
    arm = 1'b1;
    stop = 1'b1;
    tick();
    arm = 1'b0;
    stop = 1'b0;
    vecs++;
    if (rd_valid !== 1'b0 || state !== 2'd1 || count !== '0 || wrapped !== 1'b0) begin
      errs++;
      $display("FAIL abort: got v %b st %0d cnt %0d wr %b want 0 1 0 0",
               rd_valid, state, count, wrapped);
    end
    capture(1);
    do_drain("abort", 1'b0);
  endtask

  task automatic test_reset_mid();
    mode = 1'b0;
    trig_en = 1'b1;
    trig_pc = 32'h40;
    post_cnt = PW'(20);
    pulse_arm();
    set_quiet();
    tick();
    pc = 32'h40;
    tick();
    set_busy();
    tick();
    tick();
    vecs++;
    if (state !== 2'd2) begin errs++; $display("FAIL rstpost pre: got state %0d want 2", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trig_en = 1'b0;
    vecs++;
    if (state !== 2'd0 || rd_valid !== 1'b0 || count !== '0) begin
      errs++;
      $display("FAIL rstpost: got st %0d v %b cnt %0d want 0 0 0", state, rd_valid, count);
    end
    pulse_arm();
    capture(5);
    rd_ready = 1'b0;
    tick();
    tick();
    vecs++;
    if (rd_valid !== 1'b1) begin errs++; $display("FAIL rstdrain pre: got valid %b want 1", rd_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (state !== 2'd0 || rd_valid !== 1'b0 || count !== '0 || rd_last !== 1'b0) begin
      errs++;
      $display("FAIL rstdrain: got st %0d v %b cnt %0d last %b want 0 0 0 0",
               state, rd_valid, count, rd_last);
    end
    mode = 1'b0;
    pulse_arm();
    capture(3);
    do_drain("after_rst", 1'b0);
  endtask

  initial begin
    set_quiet();
    test_reset();
    test_mode0_basic();
    test_mode1_events();
    test_wrap();
    test_trigger();
    test_toggle_drain();
    test_empty_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
